// File: rtl/esc_frame_scheduler_if.sv
// Bundle between the flight controller and the ESC frame scheduler: arm/speed
// requests in, staggered PWM write strobes and speed words out.
interface esc_frame_scheduler_if;
  logic        arm;
  logic        spd_vld;
  logic [10:0] frnt_spd;
  logic [10:0] bck_spd;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic [3:0]  wrt;
  logic [10:0] frnt_out;
  logic [10:0] bck_out;
  logic [10:0] lft_out;
  logic [10:0] rght_out;
  logic        armed;
  logic        frame_start;

  // Flight-controller side
  modport master (
    output arm, spd_vld, frnt_spd, bck_spd, lft_spd, rght_spd,
    input  wrt, frnt_out, bck_out, lft_out, rght_out, armed, frame_start
  );

  // Scheduler side
  modport slave (
    input  arm, spd_vld, frnt_spd, bck_spd, lft_spd, rght_spd,
    output wrt, frnt_out, bck_out, lft_out, rght_out, armed, frame_start
  );
endinterface

// File: rtl/esc_frame_scheduler.sv
// Frame timer, staggered ESC write strobes, arm/disarm sequencing and a
// double-buffered speed set. Define ESC_SLEW_EN to enable per-frame slew limiting.
module esc_frame_scheduler #(
  parameter int FRAME_CYC  = 50000,
  parameter int STAGGER    = 3125,
  parameter int ARM_FRAMES = 8,
  parameter int SLEW_STEP  = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  esc_frame_scheduler_if.slave bus
);

  localparam int CNT_W  = $clog2(FRAME_CYC);
  localparam int ACNT_W = $clog2(ARM_FRAMES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_CYC - 1);
  localparam logic [ACNT_W-1:0] ARM_LAST = ACNT_W'(ARM_FRAMES - 1);
  localparam logic signed [11:0] STEP    = 12'(SLEW_STEP);
`ifdef ESC_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  typedef enum logic [1:0] {DISARMED, ARMING, RUN} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [ACNT_W-1:0]   arm_cnt, arm_cnt_next;
  logic                boundary;
  logic [3:0]          wrt_q;
  logic                frame_start_q;
  logic                armed_q;
  logic [10:0]         spd_in   [4];
  logic [10:0]         shadow   [4];
  logic [10:0]         spd_out  [4];
  logic [10:0]         spd_next [4];

  // One step toward tgt, never overshooting and never leaving 0..2047
  function automatic logic [10:0] slew_toward(input logic [10:0] cur,
                                              input logic [10:0] tgt);
    logic signed [11:0] diff;
    logic signed [11:0] delta;
    logic signed [12:0] sum;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP)       delta = STEP;
    else if (diff < -STEP) delta = -STEP;
    else                   delta = diff;
    sum = $signed({2'b00, cur}) + $signed({delta[11], delta});
    if (sum < 0)                 return 11'd0;
    else if (sum > 13'sd2047)    return 11'h7FF;
    else                         return sum[10:0];
  endfunction

  assign boundary  = (cnt == CNT_LAST);
  assign spd_in[0] = bus.frnt_spd;
  assign spd_in[1] = bus.bck_spd;
  assign spd_in[2] = bus.lft_spd;
  assign spd_in[3] = bus.rght_spd;

  assign bus.frnt_out    = spd_out[0];
  assign bus.bck_out     = spd_out[1];
  assign bus.lft_out     = spd_out[2];
  assign bus.rght_out    = spd_out[3];
  assign bus.wrt         = wrt_q;
  assign bus.frame_start = frame_start_q;
  assign bus.armed       = armed_q;

  // Free-running frame timer; strobes are registered off the count so they
  // land one cycle after the matching count value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      frame_start_q <= 1'b0;
      wrt_q         <= '0;
    end else begin
      cnt           <= boundary ? '0 : cnt + CNT_W'(1);
      frame_start_q <= boundary;
      for (int i = 0; i < 4; i++) begin
        wrt_q[i] <= (cnt == CNT_W'(i * STAGGER));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DISARMED;
      arm_cnt <= '0;
      armed_q <= 1'b0;
    end else begin
      state   <= state_next;
      arm_cnt <= arm_cnt_next;
      armed_q <= (state_next == RUN);
    end
  end

  // Dropping arm acts on the next edge; every other move waits for a boundary
  always_comb begin
    state_next   = state;
    arm_cnt_next = arm_cnt;
    case (state)
      DISARMED: begin
        arm_cnt_next = '0;
        if (boundary && bus.arm) state_next = ARMING;
      end
      ARMING: begin
        if (!bus.arm) begin
          state_next   = DISARMED;
          arm_cnt_next = '0;
        end else if (boundary) begin
          if (arm_cnt == ARM_LAST) begin
            state_next   = RUN;
            arm_cnt_next = '0;
          end else begin
            arm_cnt_next = arm_cnt + ACNT_W'(1);
          end
        end
      end
      RUN: begin
        if (!bus.arm) state_next = DISARMED;
      end
      default: begin
        state_next   = DISARMED;
        arm_cnt_next = '0;
      end
    endcase
  end

  // A capture on the boundary edge itself is forwarded into the new frame
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      spd_next[i] = 11'd0;
      if (state_next == RUN) begin
        spd_next[i] = bus.spd_vld ? spd_in[i] : shadow[i];
        if (SLEW_EN) spd_next[i] = slew_toward(spd_out[i], spd_next[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i]  <= '0;
        spd_out[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bus.spd_vld) shadow[i]  <= spd_in[i];
        if (boundary)    spd_out[i] <= spd_next[i];
      end
    end
  end

endmodule

// File: tb/tb_esc_frame_scheduler.sv
// Bench for esc_frame_scheduler: a frame-level reference model checked every
// cycle, plus directed arm/speed/reset scenarios with literal expectations.
module tb_esc_frame_scheduler;

  localparam int FRAME_CYC  = 400;
  localparam int STAGGER    = 100;
  localparam int ARM_FRAMES = 8;
  localparam int SLEW_STEP  = 64;
`ifdef ESC_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  esc_frame_scheduler_if bus();

  esc_frame_scheduler #(
    .FRAME_CYC (FRAME_CYC),
    .STAGGER   (STAGGER),
    .ARM_FRAMES(ARM_FRAMES),
    .SLEW_STEP (SLEW_STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: position in frame, consecutive arm-high boundaries,
  // latest captured speeds and the speed words of the current frame
  int       m_pos      = 0;
  int       m_armcnt   = 0;
  int       m_shadow[4] = '{0, 0, 0, 0};
  int       m_out[4]    = '{0, 0, 0, 0};
  logic     m_armed    = 1'b0;
  logic     m_fs       = 1'b0;
  logic [3:0] m_wrt    = 4'b0;

  function automatic int spd_of(input int i);
    case (i)
      0:       return int'(bus.frnt_spd);
      1:       return int'(bus.bck_spd);
      2:       return int'(bus.lft_spd);
      default: return int'(bus.rght_spd);
    endcase
  endfunction

  // RUN is reached once arm has stayed high across ARM_FRAMES+1 boundaries
  function automatic int nxt_armcnt(input int c, input logic arm, input logic bnd);
    if (!arm) return 0;
    if (bnd && c <= ARM_FRAMES) return c + 1;
    return c;
  endfunction

  function automatic int nxt_speed(input int cur, input int tgt, input logic run);
    if (!run) return 0;
    if (!SLEW) return tgt;
    if (tgt > cur) return (tgt - cur > SLEW_STEP) ? cur + SLEW_STEP : tgt;
    return (cur - tgt > SLEW_STEP) ? cur - SLEW_STEP : tgt;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos    <= 0;
      m_armcnt <= 0;
      m_armed  <= 1'b0;
      m_fs     <= 1'b0;
      m_wrt    <= 4'b0;
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] <= 0;
        m_out[i]    <= 0;
      end
    end else begin
      m_armcnt <= nxt_armcnt(m_armcnt, bus.arm, m_pos == FRAME_CYC - 1);
      m_armed  <= nxt_armcnt(m_armcnt, bus.arm, m_pos == FRAME_CYC - 1) > ARM_FRAMES;
      m_pos    <= (m_pos + 1) % FRAME_CYC;
      m_fs     <= ((m_pos + 1) % FRAME_CYC) == 0;
      for (int i = 0; i < 4; i++) begin
        m_wrt[i] <= ((m_pos + 1) % FRAME_CYC) == i * STAGGER + 1;
        if (bus.spd_vld) m_shadow[i] <= spd_of(i);
        if (m_pos == FRAME_CYC - 1)
          m_out[i] <= nxt_speed(m_out[i], bus.spd_vld ? spd_of(i) : m_shadow[i],
                                nxt_armcnt(m_armcnt, bus.arm, 1'b1) > ARM_FRAMES);
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check_output("wrt",         32'(bus.wrt),         32'(m_wrt));
    check_output("frame_start", 32'(bus.frame_start), 32'(m_fs));
    check_output("armed",       32'(bus.armed),       32'(m_armed));
    check_output("frnt_out",    32'(bus.frnt_out),    m_out[0]);
    check_output("bck_out",     32'(bus.bck_out),     m_out[1]);
    check_output("lft_out",     32'(bus.lft_out),     m_out[2]);
    check_output("rght_out",    32'(bus.rght_out),    m_out[3]);
  end

  task automatic apply_stimulus(input logic arm, input logic vld, input int f,
                                input int b, input int l, input int r);
    bus.arm      = arm;
    bus.spd_vld  = vld;
    bus.frnt_spd = 11'(f);
    bus.bck_spd  = 11'(b);
    bus.lft_spd  = 11'(l);
    bus.rght_spd = 11'(r);
  endtask

  // Advance at least one cycle, then stop at the negedge where the frame
  // position equals p; a missed position counts as a failure
  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_pos != p && n < FRAME_CYC + 2);
    if (m_pos != p) check_output("wait_pos", 32'(m_pos), 32'(p));
  endtask

  initial begin
    apply_stimulus(1'b0, 1'b0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_output("reset_wrt",   32'(bus.wrt), 0);
    check_output("reset_armed", 32'(bus.armed), 0);
    check_output("reset_frnt",  32'(bus.frnt_out), 0);
    check_output("reset_fs",    32'(bus.frame_start), 0);
    #2 rst_n = 1'b1;

    @(negedge clk);
    check_output("first_wrt0", 32'(bus.wrt), 32'h1);
    wait_pos(3 * STAGGER + 1);
    check_output("wrt3_pos", 32'(bus.wrt), 32'h8);
    for (int k = 0; k < 3; k++) begin
      wait_pos(0);
      check_output("disarmed_fs",    32'(bus.frame_start), 1);
      check_output("disarmed_armed", 32'(bus.armed), 0);
    end

    // Arm with speeds 1000 captured mid-frame
    wait_pos(100);
    apply_stimulus(1'b1, 1'b1, 1000, 1000, 1000, 1000);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 1000, 1000, 1000, 1000);
    for (int k = 1; k <= ARM_FRAMES; k++) begin
      wait_pos(0);
      check_output("arming_armed", 32'(bus.armed), 0);
      check_output("arming_frnt",  32'(bus.frnt_out), 0);
    end
    wait_pos(0);
    check_output("run_armed", 32'(bus.armed), 1);
    check_output("run_frnt",  32'(bus.frnt_out), SLEW ? 64 : 1000);
    check_output("run_rght",  32'(bus.rght_out), SLEW ? 64 : 1000);

    // Mid-frame capture must not leak; boundary capture overwrites and forwards
    wait_pos(50);
    apply_stimulus(1'b1, 1'b1, 300, 1500, 7, 2047);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 0, 0, 0, 0);
    wait_pos(60);
    check_output("hold_frnt", 32'(bus.frnt_out), SLEW ? 64 : 1000);
    wait_pos(FRAME_CYC - 1);
    apply_stimulus(1'b1, 1'b1, 2047, 1500, 7, 2047);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 0, 0, 0, 0);
    check_output("fwd_frnt", 32'(bus.frnt_out), SLEW ? 128 : 2047);
    check_output("fwd_bck",  32'(bus.bck_out),  SLEW ? 128 : 1500);
    check_output("fwd_lft",  32'(bus.lft_out),  7);
    check_output("fwd_rght", 32'(bus.rght_out), SLEW ? 128 : 2047);
    repeat (32) wait_pos(0);
    check_output("settle_frnt", 32'(bus.frnt_out), 2047);
    check_output("settle_bck",  32'(bus.bck_out),  1500);

    // Disarm mid-frame in RUN
    wait_pos(200);
    bus.arm = 1'b0;
    @(negedge clk);
    check_output("disarm_armed", 32'(bus.armed), 0);
    check_output("disarm_hold",  32'(bus.frnt_out), 2047);
    wait_pos(3 * STAGGER + 1);
    check_output("disarm_wrt3", 32'(bus.wrt), 32'h8);
    wait_pos(0);
    check_output("disarm_frnt", 32'(bus.frnt_out), 0);
    check_output("disarm_bck",  32'(bus.bck_out), 0);
    wait_pos(1);
    check_output("disarm_wrt0", 32'(bus.wrt), 32'h1);

    // Arming interrupted in its fifth frame restarts the full count
    wait_pos(10);
    bus.arm = 1'b1;
    repeat (5) wait_pos(0);
    wait_pos(100);
    bus.arm = 1'b0;
    wait_pos(200);
    bus.arm = 1'b1;
    for (int k = 1; k <= ARM_FRAMES; k++) begin
      wait_pos(0);
      check_output("rearm_armed", 32'(bus.armed), 0);
      check_output("rearm_frnt",  32'(bus.frnt_out), 0);
    end
    wait_pos(0);
    check_output("rearm_run",  32'(bus.armed), 1);
    check_output("rearm_frnt", 32'(bus.frnt_out), SLEW ? 64 : 2047);
    check_output("rearm_bck",  32'(bus.bck_out),  SLEW ? 64 : 1500);
    check_output("rearm_lft",  32'(bus.lft_out),  7);

    // Reset mid-frame in RUN
    wait_pos(150);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_frnt",  32'(bus.frnt_out), 0);
    check_output("rst_rght",  32'(bus.rght_out), 0);
    check_output("rst_armed", 32'(bus.armed), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_pos(1);
    check_output("rst_wrt0", 32'(bus.wrt), 32'h1);
    repeat (2) begin
      wait_pos(0);
      check_output("rst_disarmed", 32'(bus.armed), 0);
      check_output("rst_frnt0",    32'(bus.frnt_out), 0);
    end
    bus.arm = 1'b0;
    wait_pos(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
